// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a single sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Valid/ready: Start is taken only in S_IDLE with Flush low; Busy is the
  // not-ready indication and Done pulses for one cycle when HI/LO are written.

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               negr_q, negr_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   dsor_q, dsor_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic               signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     madd;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;

  assign signed_op = (Op == 3'd0) || (Op == 3'd2);
  assign mag_a     = (signed_op && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign mag_b     = (signed_op && OperandB[WIDTH-1]) ? -OperandB : OperandB;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    negr_d    = negr_q;
    dz_d      = dz_q;
    dsor_d    = dsor_q;
    work_d    = work_q;
    rem_d     = rem_q;
    madd      = '0;
    rem_shift = '0;
    rem_diff  = '0;
    q_bit     = 1'b0;
    prod_fix  = '0;
    quo       = '0;

    case (state_q)
      S_IDLE: begin
        if (Start && !Flush) begin
          case (Op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d = Op[1];
              neg_d    = signed_op && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
              negr_d   = signed_op && OperandA[WIDTH-1];
              dz_d     = Op[1] && (OperandB == '0);
              cnt_d    = '0;
              rem_d    = '0;
              // Multiply: dsor holds the multiplicand, work low half the multiplier.
              // Divide: dsor holds the divisor, work low half the dividend/quotient.
              dsor_d   = Op[1] ? mag_b : mag_a;
              work_d   = {{WIDTH{1'b0}}, (Op[1] ? mag_a : mag_b)};
              state_d  = S_CALC;
            end
            3'd4: hi_d = OperandA;
            3'd5: lo_d = OperandA;
            default: ;
          endcase
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          rem_shift = {rem_q, work_q[WIDTH-1]};
          rem_diff  = rem_shift - {1'b0, dsor_q};
          q_bit     = (rem_shift >= {1'b0, dsor_q});
          rem_d     = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          work_d    = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-2:0], q_bit};
        end else begin
          madd   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, dsor_q} : '0);
          work_d = {madd, work_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          // With a zero divisor the remainder path rebuilds |A|, so re-applying
          // the dividend sign returns the original OperandA in HI.
          quo  = work_q[WIDTH-1:0];
          lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
          hi_d = negr_q ? -rem_q : rem_q;
        end else begin
          prod_fix = neg_q ? -work_q : work_q;
          hi_d     = prod_fix[2*WIDTH-1:WIDTH];
          lo_d     = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (Flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      dsor_q   <= '0;
      work_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      dsor_q   <= dsor_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
    end
  end

  assign HI          = hi_q;
  assign LO          = lo_q;
  assign Busy        = (state_q != S_IDLE);
  assign Done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: reference model feeds an expected
// queue at issue time; a negedge monitor pops and compares on every Done.
module tb_mult_div_unit;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        Flush;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  logic [31:0] hi_m, lo_m;
  int          checks;
  int          failures;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Op          (Op),
    .OperandA    (OperandA),
    .OperandB    (OperandB),
    .Flush       (Flush),
    .HI          (HI),
    .LO          (LO),
    .Busy        (Busy),
    .Done        (Done),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    model = 64'd0;
    case (op)
      3'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        model = sp;
      end
      3'd1: model = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) model = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = {32'd0, 32'h80000000};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r, q};
        end
      end
      3'd3: begin
        if (b == 32'd0) model = {a, 32'hFFFFFFFF};
        else model = {a % b, a / b};
      end
      default: model = 64'd0;
    endcase
  endfunction

  // Driver tasks: callers sit at posedge+#1
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    Start = 1'b1;
    Op = op;
    OperandA = a;
    OperandB = b;
    if (push) begin
      if (op <= 3'd3) exp_q.push_back(model(op, a, b));
      if (op == 3'd4) hi_m = a;
      if (op == 3'd5) lo_m = a;
    end
    step();
    Start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!Done && lat < 60) begin
      if (Busy) busy_n++;
      step();
      lat++;
    end
    if (!Done) check("done_timeout", {63'd0, Done}, 64'd1);
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    if (Reset && Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {63'd0, Done}, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result", {HI, LO}, e);
        check("busy_at_done", {63'd0, Busy}, 64'd0);
        hi_m = e[63:32];
        lo_m = e[31:0];
      end
    end
  end

  initial begin
    int lat, busy_n, done_seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    checks = 0;
    failures = 0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    Reset = 1'b0;
    Start = 1'b0;
    Flush = 1'b0;
    Op = 3'd0;
    OperandA = 32'd0;
    OperandB = 32'd0;
    repeat (3) step();
    Reset = 1'b1;
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    step();

    // MULTU max * max: latency and busy length
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    wait_done(lat, busy_n);
    check("multu_latency", lat, 33);
    check("multu_busy_cycles", busy_n, 33);
    check("multu_hi", {32'd0, HI}, {32'd0, 32'hFFFFFFFE});
    check("multu_lo", {32'd0, LO}, 64'd1);
    step();
    check("done_one_cycle", {63'd0, Done}, 64'd0);

    // MULT -3*7, then DIV -7/2 started on the Done cycle
    issue(3'd0, 32'hFFFFFFFD, 32'd7, 1);
    wait_done(lat, busy_n);
    check("mult_hi", {32'd0, HI}, {32'd0, 32'hFFFFFFFF});
    check("mult_lo", {32'd0, LO}, {32'd0, 32'hFFFFFFEB});
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1);
    wait_done(lat, busy_n);
    check("b2b_latency", lat, 33);
    check("div_lo", {32'd0, LO}, {32'd0, 32'hFFFFFFFD});
    check("div_hi", {32'd0, HI}, {32'd0, 32'hFFFFFFFF});
    step();

    // Divide by zero and signed overflow
    issue(3'd3, 32'd100, 32'd0, 1);
    wait_done(lat, busy_n);
    check("divz_latency", lat, 33);
    check("divz_lo", {32'd0, LO}, {32'd0, 32'hFFFFFFFF});
    check("divz_hi", {32'd0, HI}, 64'd100);
    step();
    issue(3'd2, 32'hFFFFFFF9, 32'd0, 1);
    wait_done(lat, busy_n);
    step();
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1);
    wait_done(lat, busy_n);
    check("ovf_lo", {32'd0, LO}, {32'd0, 32'h80000000});
    check("ovf_hi", {32'd0, HI}, 64'd0);
    step();

    // MTHI then MTLO on consecutive cycles
    issue(3'd4, 32'h12345678, 32'd0, 1);
    check("mthi_hi", {32'd0, HI}, {32'd0, 32'h12345678});
    check("mthi_busy", {63'd0, Busy}, 64'd0);
    issue(3'd5, 32'h9ABCDEF0, 32'd0, 1);
    check("mtlo_lo", {32'd0, LO}, {32'd0, 32'h9ABCDEF0});
    check("mtlo_hi_kept", {32'd0, HI}, {32'd0, 32'h12345678});
    check("mtlo_done", {63'd0, Done}, 64'd0);

    // Reserved op has no effect
    issue(3'd6, 32'hCAFEF00D, 32'd3, 0);
    check("rsvd_busy", {63'd0, Busy}, 64'd0);
    check("rsvd_hilo", {HI, LO}, {hi_m, lo_m});

    // Start while busy is ignored
    issue(3'd1, 32'd3, 32'd5, 1);
    repeat (4) step();
    issue(3'd1, 32'd7, 32'd9, 0);
    wait_done(lat, busy_n);
    check("ign_latency", lat, 28);
    repeat (40) step();
    check("ign_hilo", {HI, LO}, 64'd15);

    // Flush mid-divide
    issue(3'd3, 32'd50, 32'd7, 0);
    repeat (9) step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check("flush_busy", {63'd0, Busy}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      if (Done) done_seen++;
      step();
    end
    check("flush_no_done", done_seen, 0);
    check("flush_hilo", {HI, LO}, {hi_m, lo_m});

    // Flush in IDLE blocks a same-cycle MTHI
    Flush = 1'b1;
    issue(3'd4, 32'hDEADBEEF, 32'd0, 0);
    Flush = 1'b0;
    check("idle_flush_hi", {32'd0, HI}, {32'd0, hi_m});

    // Reset mid-divide
    issue(3'd3, 32'd50, 32'd7, 0);
    repeat (19) step();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    check("mid_rst_hilo", {HI, LO}, 64'd0);
    check("mid_rst_busy", {63'd0, Busy}, 64'd0);
    check("mid_rst_done", {63'd0, Done}, 64'd0);
    repeat (40) step();
    check("mid_rst_stay", {HI, LO}, 64'd0);

    // Random mult/div traffic
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 4) == 0) rb = 32'd0;
      else if (i % 2 == 1) rb = 32'($urandom_range(1, 20));
      else rb = $urandom;
      if (i % 3 == 0) ra = -32'($urandom_range(1, 1000));
      issue(rop, ra, rb, 1);
      wait_done(lat, busy_n);
      check("rand_latency", lat, 33);
      step();
    end

    repeat (5) step();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit with architectural HI/LO registers, sitting beside the Execute stage.
- The ID/EX outputs (operands Reg_Data1/Reg_Data2 plus decoded funct) drive it.
- Its Busy output stalls the fetch/decode pipeline registers.
- HI/LO feed the Execute result mux for MFHI/MFLO.
- Covers MULT, MULTU, DIV, DIVU, MTHI and MTLO.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- ITER, 32, compute iterations per mult/div; must equal WIDTH.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  request pulse; sampled only in IDLE.
- Op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (ignored).
- OperandA  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source).
- OperandB  in  WIDTH  rt value (divisor / multiplier).
- Flush  in  1  abort in-flight op (branch/jump squash).
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- Busy  out  1  high while an op is in flight; stall request.
- Done  out  1  one-cycle pulse when HI/LO take a mult/div result.

Behaviour:
- Reset (Reset=0 at an edge):
  - state=IDLE; HI=0, LO=0; Busy=0, Done=0.
  - Internal counter and work registers cleared.
  - Any in-flight op is discarded, including mid-operation.
- States: IDLE, CALC, FIX.
- IDLE, Start=1, Op in 0..3:
  - Latch magnitudes. Signed ops take |A| and |B|; unsigned ops take raw values.
  - Latch sign flags (signed ops only): negP = A[31]^B[31]; negQ = A[31]^B[31]; negR = A[31].
  - counter=0, state=CALC, Busy=1 from the next cycle.
- IDLE, Start=1, Op=4/5:
  - HI (Op 4) or LO (Op 5) loads OperandA on that edge.
  - Stay in IDLE; Busy and Done stay 0.
- IDLE, Start=1, Op=6/7: no effect.
- CALC:
  - One iteration per cycle; counter increments; after ITER iterations (counter==ITER-1) go to FIX.
  - Multiply: shift-add, 64-bit unsigned product accumulator.
  - Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
- FIX (one cycle):
  - Apply sign correction.
  - Multiply: {HI,LO} = negP ? -P : P (64-bit two's complement).
  - Divide: LO = negQ ? -Q : Q; HI = negR ? -R : R.
  - Writes HI/LO, Done=1 and Busy=0 on that edge, then state=IDLE.
- Latency: Start sampled at edge E0 → HI/LO/Done valid after edge E0+33. Busy=1 for exactly 33 cycles. Done lasts one cycle.
- Back-to-back: a new Start is accepted on the cycle Done is high (state already IDLE).
- Start while Busy=1: ignored, no queueing.
- Divide by zero (B==0), DIV and DIVU alike:
  - LO=32'hFFFFFFFF, HI=OperandA as latched.
  - Sign correction suppressed.
  - Same 33-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
- Flush=1 in CALC or FIX:
  - Return to IDLE on that edge; HI/LO unchanged.
  - Busy=0 next cycle; Done never asserts.
- Flush in IDLE: no effect, and it blocks a same-cycle Start.
- Reset has priority over Flush, and Flush over Start.
- MFHI/MFLO reads are combinational from the HI/LO outputs. The consumer must stall while Busy=1; the unit does not forward.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF, Start at E0 → Busy high E0+1..E0+33; after E0+33 HI=0xFFFFFFFE, LO=0x00000001, Done=1 for one cycle.
- MULT A=0xFFFFFFFD(-3) B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV A=0xFFFFFFF9(-7) B=2 started on the Done cycle → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100 B=0 → LO=0xFFFFFFFF, HI=100 after 33 cycles; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles → HI/LO updated the next edge each, Busy=0, Done=0. A Start with a new MULTU issued 5 cycles into a prior MULTU → ignored, only the first result written.
- Flush at cycle 10 of DIVU 50/7 → Busy=0 next cycle, Done never asserts, HI/LO keep prior values. Repeat with Reset=0 at cycle 20 → HI=LO=0, Busy=0, Done=0.
